// File: rtl/ms_open_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ms_open_ctrl: cursor-driven open/flag controller with zero-region flood    |
// | fill. Optional flood engine enabled by defining MS_FLOOD_EN.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ms_open_ctrl #(
   parameter int X_SIZE      = 16,
   parameter int Y_SIZE      = 16,
   parameter int X_BITS      = 4,
   parameter int Y_BITS      = 4,
   parameter int STACK_DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     board_ready,
   input  logic [X_BITS-1:0]        cur_x,
   input  logic [Y_BITS-1:0]        cur_y,
   input  logic                     open_req,
   input  logic                     flag_req,
   input  logic                     new_game,
   input  logic [X_BITS+Y_BITS-1:0] num_mines,
   input  logic [4:0]               board_cell,
   input  logic [1:0]               cover_cell,
   output logic [X_BITS-1:0]        x_coord,
   output logic [Y_BITS-1:0]        y_coord,
   output logic                     cover_open,
   output logic                     cover_flag,
   output logic                     busy,
   output logic                     game_over,
   output logic                     game_won,
   output logic [X_BITS+Y_BITS:0]   opened_cnt
);

   localparam int c_CNT_W = X_BITS + Y_BITS + 1;
   localparam int c_TOTAL = X_SIZE * Y_SIZE;

`ifdef MS_FLOOD_EN
   typedef enum logic [2:0] {
      IDLE = 3'd0, U_RD = 3'd1, U_CHK = 3'd2, LOST = 3'd3,
      WON  = 3'd4, POP  = 3'd5, N_RD  = 3'd6, N_CHK = 3'd7
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE = 3'd0, U_RD = 3'd1, U_CHK = 3'd2, LOST = 3'd3, WON = 3'd4
   } state_t;
`endif

   state_t               r_state, w_next;
   logic [X_BITS-1:0]    r_cx;
   logic [Y_BITS-1:0]    r_cy;
   logic                 r_flag_mode;
   logic [c_CNT_W-1:0]   r_cnt;
   logic                 r_over, r_won;
   logic                 w_latch, w_inc;
   logic [c_CNT_W-1:0]   w_target;

   assign w_target = c_CNT_W'(c_TOTAL) - {1'b0, num_mines};

`ifdef MS_FLOOD_EN
   localparam int c_SP_W = $clog2(STACK_DEPTH + 1);
   localparam int c_AW   = $clog2(STACK_DEPTH);

   logic [X_BITS+Y_BITS-1:0] r_stack [STACK_DEPTH];
   logic [c_SP_W-1:0]        r_sp, w_sp_m1;
   logic [2:0]               r_k;
   logic                     w_push, w_push_nb, w_pop, w_k_inc, w_push_ok;
   logic [X_BITS-1:0]        w_nb_x;
   logic [Y_BITS-1:0]        w_nb_y;
   logic                     w_nb_valid;
   logic [X_BITS+Y_BITS-1:0] w_push_data;

   assign w_sp_m1     = r_sp - c_SP_W'(1);
   assign w_push_ok   = w_push && (r_sp != c_SP_W'(STACK_DEPTH));
   assign w_push_data = w_push_nb ? {w_nb_y, w_nb_x} : {r_cy, r_cx};

   // Neighbour k order: row above (k=0..2), same row (3,4), row below (5..7).
   always_comb begin
      w_nb_x     = r_cx;
      w_nb_y     = r_cy;
      w_nb_valid = 1'b1;
      case (r_k)
         3'd0, 3'd3, 3'd5: begin
            w_nb_x = r_cx - X_BITS'(1);
            if (r_cx == '0) w_nb_valid = 1'b0;
         end
         3'd2, 3'd4, 3'd7: begin
            w_nb_x = r_cx + X_BITS'(1);
            if (r_cx == X_BITS'(X_SIZE - 1)) w_nb_valid = 1'b0;
         end
         default: ;
      endcase
      case (r_k)
         3'd0, 3'd1, 3'd2: begin
            w_nb_y = r_cy - Y_BITS'(1);
            if (r_cy == '0) w_nb_valid = 1'b0;
         end
         3'd5, 3'd6, 3'd7: begin
            w_nb_y = r_cy + Y_BITS'(1);
            if (r_cy == Y_BITS'(Y_SIZE - 1)) w_nb_valid = 1'b0;
         end
         default: ;
      endcase
   end
`else
   logic w_unused_count;
   assign w_unused_count = |board_cell[3:0];
`endif

   always_comb begin
      w_next     = r_state;
      cover_open = 1'b0;
      cover_flag = 1'b0;
      w_inc      = 1'b0;
      w_latch    = 1'b0;
`ifdef MS_FLOOD_EN
      w_push     = 1'b0;
      w_push_nb  = 1'b0;
      w_pop      = 1'b0;
      w_k_inc    = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (board_ready && (open_req || flag_req)) begin
               w_latch = 1'b1;
               w_next  = U_RD;
            end
         end
         U_RD: w_next = U_CHK;
         U_CHK: begin
            w_next = IDLE;
            if (!cover_cell[0]) begin
               if (r_flag_mode) begin
                  cover_flag = 1'b1;
               end else if (!cover_cell[1]) begin
                  cover_open = 1'b1;
                  if (board_cell[4]) begin
                     w_next = LOST;
                  end else begin
                     w_inc = 1'b1;
`ifdef MS_FLOOD_EN
                     if (board_cell[3:0] == 4'd0) begin
                        w_push = 1'b1;
                        w_next = POP;
                     end
`endif
                  end
               end
            end
         end
`ifdef MS_FLOOD_EN
         POP: begin
            if (r_sp == '0) begin
               w_next = IDLE;
            end else begin
               w_pop  = 1'b1;
               w_next = N_RD;
            end
         end
         N_RD: begin
            // Off-board neighbours are skipped without a read cycle.
            if (w_nb_valid)         w_next  = N_CHK;
            else if (r_k == 3'd7)   w_next  = POP;
            else                    w_k_inc = 1'b1;
         end
         N_CHK: begin
            if (!cover_cell[0] && !cover_cell[1] && !board_cell[4]) begin
               cover_open = 1'b1;
               w_inc      = 1'b1;
               if (board_cell[3:0] == 4'd0) begin
                  w_push    = 1'b1;
                  w_push_nb = 1'b1;
               end
            end
            if (r_k == 3'd7) begin
               w_next = POP;
            end else begin
               w_k_inc = 1'b1;
               w_next  = N_RD;
            end
         end
`endif
         LOST, WON: ;
         default: w_next = IDLE;
      endcase

      if (new_game) begin
         w_next     = IDLE;
         w_latch    = 1'b0;
         w_inc      = 1'b0;
         cover_open = 1'b0;
         cover_flag = 1'b0;
`ifdef MS_FLOOD_EN
         w_push     = 1'b0;
         w_pop      = 1'b0;
`endif
      end else if (w_next != LOST && r_state != LOST && r_state != WON &&
                   r_cnt == w_target) begin
         w_next = WON;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_cx        <= '0;
         r_cy        <= '0;
         r_flag_mode <= 1'b0;
         r_cnt       <= '0;
         r_over      <= 1'b0;
         r_won       <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_latch) begin
            r_cx        <= cur_x;
            r_cy        <= cur_y;
            r_flag_mode <= !open_req;
         end
`ifdef MS_FLOOD_EN
         else if (w_pop) begin
            {r_cy, r_cx} <= r_stack[w_sp_m1[c_AW-1:0]];
         end
`endif
         if (new_game) begin
            r_cnt  <= '0;
            r_over <= 1'b0;
            r_won  <= 1'b0;
         end else begin
            if (w_inc)          r_cnt  <= r_cnt + c_CNT_W'(1);
            if (w_next == LOST) r_over <= 1'b1;
            if (w_next == WON)  r_won  <= 1'b1;
         end
      end
   end

`ifdef MS_FLOOD_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sp <= '0;
         r_k  <= '0;
      end else if (new_game) begin
         r_sp <= '0;
      end else begin
         if (w_pop)          r_sp <= w_sp_m1;
         else if (w_push_ok) r_sp <= r_sp + c_SP_W'(1);
         if (w_pop)          r_k  <= '0;
         else if (w_k_inc)   r_k  <= r_k + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) r_stack[r_sp[c_AW-1:0]] <= w_push_data;
   end
`endif

   always_comb begin
      x_coord = cur_x;
      y_coord = cur_y;
      case (r_state)
         U_RD, U_CHK: begin
            x_coord = r_cx;
            y_coord = r_cy;
         end
`ifdef MS_FLOOD_EN
         N_RD, N_CHK: begin
            x_coord = w_nb_valid ? w_nb_x : r_cx;
            y_coord = w_nb_valid ? w_nb_y : r_cy;
         end
`endif
         default: ;
      endcase
   end

   assign busy       = (r_state != IDLE) && (r_state != LOST) && (r_state != WON);
   assign game_over  = r_over;
   assign game_won   = r_won;
   assign opened_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ms_open_ctrl.sv
`default_nettype none
// Directed bench for ms_open_ctrl with synchronous-read board/cover models.
module tb_ms_open_ctrl;

   logic       clk = 1'b0;
   logic       reset, board_ready, open_req, flag_req, new_game, clr_cover;
   logic [3:0] cur_x, cur_y, x_coord, y_coord;
   logic [7:0] num_mines;
   logic [4:0] board_cell;
   logic [1:0] cover_cell;
   logic       cover_open, cover_flag, busy, game_over, game_won;
   logic [8:0] opened_cnt;

   logic [4:0] board_mem [256];
   logic [1:0] cover_mem [256];

   int checks = 0, errors = 0;
   int n_open = 0, n_flag = 0, n_bad = 0, n_dup = 0;
   int b_open, b_flag, b_bad, b_dup;

   always #5 clk = ~clk;

   ms_open_ctrl dut (
      .clk(clk), .reset(reset), .board_ready(board_ready),
      .cur_x(cur_x), .cur_y(cur_y), .open_req(open_req), .flag_req(flag_req),
      .new_game(new_game), .num_mines(num_mines), .board_cell(board_cell),
      .cover_cell(cover_cell), .x_coord(x_coord), .y_coord(y_coord),
      .cover_open(cover_open), .cover_flag(cover_flag), .busy(busy),
      .game_over(game_over), .game_won(game_won), .opened_cnt(opened_cnt)
   );

   always @(posedge clk) begin
      board_cell <= board_mem[{y_coord, x_coord}];
      cover_cell <= cover_mem[{y_coord, x_coord}];
      if (clr_cover) begin
         for (int i = 0; i < 256; i++) cover_mem[i] <= 2'b00;
      end else begin
         if (cover_open) cover_mem[{y_coord, x_coord}][0] <= 1'b1;
         if (cover_flag) cover_mem[{y_coord, x_coord}][1] <= ~cover_mem[{y_coord, x_coord}][1];
      end
   end

   always @(negedge clk) begin
      if (reset && cover_open) begin
         n_open++;
         if ({y_coord, x_coord} == 8'hFF) n_bad++;
         if (cover_mem[{y_coord, x_coord}][0]) n_dup++;
      end
      if (reset && cover_flag) n_flag++;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic [3:0] x, input logic [3:0] y, input logic o, input logic f);
      cur_x = x; cur_y = y; open_req = o; flag_req = f;
      tick();
      open_req = 1'b0; flag_req = 1'b0;
   endtask

   task automatic clear_board();
      for (int i = 0; i < 256; i++) board_mem[i] = 5'd0;
   endtask

   initial begin
      reset = 1'b0; board_ready = 1'b0; open_req = 1'b0; flag_req = 1'b0;
      new_game = 1'b0; cur_x = 4'd0; cur_y = 4'd0; num_mines = 8'd10; clr_cover = 1'b1;
      clear_board();
      tick(3);
      chk("rst_busy", busy, 1'b0);
      chk("rst_over", game_over, 1'b0);
      chk("rst_won", game_won, 1'b0);
      chk("rst_cnt", opened_cnt, 9'd0);
      chk("rst_open", cover_open, 1'b0);
      chk("rst_flag", cover_flag, 1'b0);
      reset = 1'b1; clr_cover = 1'b0;
      tick();

      // single non-zero cell open
      board_mem[8'h01] = 5'd2; board_ready = 1'b1;
      req(4'd1, 4'd0, 1'b1, 1'b0);
      chk("t2_busy", busy, 1'b1);
      chk("t2_no_early_open", cover_open, 1'b0);
      tick();
      chk("t2_open", cover_open, 1'b1);
      chk("t2_x", x_coord, 4'd1);
      chk("t2_y", y_coord, 4'd0);
      tick();
      chk("t2_open_end", cover_open, 1'b0);
      chk("t2_idle", busy, 1'b0);
      chk("t2_cnt", opened_cnt, 9'd1);

      // board not ready
      board_ready = 1'b0; b_open = n_open;
      req(4'd2, 4'd1, 1'b1, 1'b0);
      tick(3);
      chk("t6_nr_opens", n_open - b_open, 0);
      chk("t6_nr_busy", busy, 1'b0);
      board_ready = 1'b1;

      // flag then open the same cell; then same-cycle open+flag
      board_mem[8'h22] = 5'd1; board_mem[8'h44] = 5'd1;
      b_open = n_open; b_flag = n_flag;
      req(4'd2, 4'd2, 1'b0, 1'b1);
      tick();
      chk("t5_flag", cover_flag, 1'b1);
      chk("t5_flag_noopen", cover_open, 1'b0);
      tick();
      req(4'd2, 4'd2, 1'b1, 1'b0);
      tick(3);
      chk("t5_flagged_opens", n_open - b_open, 0);
      chk("t5_flags", n_flag - b_flag, 1);
      chk("t5_cnt", opened_cnt, 9'd1);
      req(4'd4, 4'd4, 1'b1, 1'b1);
      tick();
      chk("t5_both_open", cover_open, 1'b1);
      chk("t5_both_flag", cover_flag, 1'b0);
      tick();
      chk("t5_both_cnt", opened_cnt, 9'd2);
      chk("t5_flags_after", n_flag - b_flag, 1);

      // mine hit
      board_mem[8'h33] = 5'h11;
      req(4'd3, 4'd3, 1'b1, 1'b0);
      tick();
      chk("t3_open", cover_open, 1'b1);
      tick();
      chk("t3_over", game_over, 1'b1);
      chk("t3_busy", busy, 1'b0);
      chk("t3_cnt", opened_cnt, 9'd2);
      b_open = n_open;
      req(4'd0, 4'd0, 1'b1, 1'b0);
      tick(3);
      chk("t3_dropped", n_open - b_open, 0);
      chk("t3_over_sticky", game_over, 1'b1);
      new_game = 1'b1; clr_cover = 1'b1;
      tick();
      new_game = 1'b0; clr_cover = 1'b0;
      chk("ng_over", game_over, 1'b0);
      chk("ng_cnt", opened_cnt, 9'd0);
      chk("ng_busy", busy, 1'b0);
      tick();

`ifdef MS_FLOOD_EN
      clear_board();
      board_mem[8'hFF] = 5'h10;
      board_mem[8'hEE] = 5'd1; board_mem[8'hEF] = 5'd1; board_mem[8'hFE] = 5'd1;
      num_mines = 8'd1;

      // reset in the middle of a flood
      req(4'd0, 4'd0, 1'b1, 1'b0);
      tick(20);
      chk("t1_busy_pre", busy, 1'b1);
      reset = 1'b0;
      #1;
      chk("t1_async_busy", busy, 1'b0);
      chk("t1_async_open", cover_open, 1'b0);
      clr_cover = 1'b1;
      tick();
      chk("t1_busy", busy, 1'b0);
      chk("t1_cnt", opened_cnt, 9'd0);
      chk("t1_open", cover_open, 1'b0);
      reset = 1'b1; clr_cover = 1'b0;
      tick();

      // full-board flood
      b_open = n_open; b_bad = n_bad; b_dup = n_dup;
      req(4'd0, 4'd0, 1'b1, 1'b0);
      for (int c = 0; c < 20000; c++) begin
         if (game_won) break;
         tick();
      end
      chk("t4_won", game_won, 1'b1);
      chk("t4_opens", n_open - b_open, 255);
      chk("t4_mine_open", n_bad - b_bad, 0);
      chk("t4_dup_open", n_dup - b_dup, 0);
      chk("t4_cnt", opened_cnt, 9'd255);
      chk("t4_over", game_over, 1'b0);
      chk("t4_busy", busy, 1'b0);
`else
      clear_board();

      // reset while a request is in flight
      req(4'd7, 4'd7, 1'b1, 1'b0);
      chk("t1_busy_pre", busy, 1'b1);
      reset = 1'b0;
      #1;
      chk("t1_async_busy", busy, 1'b0);
      clr_cover = 1'b1;
      tick();
      chk("t1_busy", busy, 1'b0);
      chk("t1_cnt", opened_cnt, 9'd0);
      chk("t1_open", cover_open, 1'b0);
      reset = 1'b1; clr_cover = 1'b0;
      tick();

      // zero cell opens only itself; one safe cell wins
      num_mines = 8'd255; b_open = n_open;
      req(4'd5, 4'd5, 1'b1, 1'b0);
      chk("t4_busy1", busy, 1'b1);
      tick();
      chk("t4_open", cover_open, 1'b1);
      tick();
      chk("t4_busy_done", busy, 1'b0);
      chk("t4_cnt", opened_cnt, 9'd1);
      tick();
      chk("t4_won", game_won, 1'b1);
      chk("t4_opens", n_open - b_open, 1);
`endif

      // requests dropped in WON, then new_game
      b_open = n_open;
      req(4'd8, 4'd8, 1'b1, 1'b0);
      tick(3);
      chk("t6_won_dropped", n_open - b_open, 0);
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
      chk("t6_won_clr", game_won, 1'b0);
      chk("t6_cnt_clr", opened_cnt, 9'd0);
      chk("t6_idle", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
